prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 8: instruction-memory address width; max program length 2^ADDR_W words.
REQ-002 Parameter SYNC, default 8'hA5: header byte that opens a load frame.
REQ-003 i_clk  input  1  single clock; all state changes on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_byte  input  8  incoming serial-link byte.
REQ-006 i_valid  input  1  i_byte valid this cycle; byte consumed when i_valid && o_ready.
REQ-007 o_ready  output  1  loader can accept a byte this cycle.
REQ-008 o_instr  output  16  assembled instruction to CPU i_instr.
REQ-009 o_addr  output  ADDR_W  instruction-memory write address.
REQ-010 o_we  output  1  one-cycle instruction-memory write strobe to CPU i_we.
REQ-011 o_cpu_rst  output  1  holds CPU in reset while loading or in error.
REQ-012 o_done  output  1  program loaded and checksum good; CPU running.
REQ-013 o_err  output  1  last frame failed checksum.

Function
REQ-014 Frame format: SYNC, LEN (word count N, 0 means 2^ADDR_W), N x {high byte, low byte}, CHK (XOR of LEN and all data bytes).
REQ-015 States: IDLE, LEN, HI, LO, WRITE, CHK, RUN, ERR.
REQ-016 IDLE: consumed byte == SYNC -> LEN; other bytes discarded.
REQ-017 LEN: consumed byte stored as word count, checksum register initialised to that byte, address counter cleared -> HI.
REQ-018 HI: consumed byte latched into o_instr[15:8] -> LO; LO: byte into o_instr[7:0] -> WRITE.
REQ-019 WRITE: o_we high exactly one cycle with stable o_instr/o_addr; o_ready low; then address increments; if words written == N -> CHK else -> HI.
REQ-020 Address counter wraps only after the 2^ADDR_W-th word, which coincides with N=0 completion; no extra writes occur.
REQ-021 CHK: consumed byte == running XOR -> RUN; mismatch -> ERR.
REQ-022 RUN: o_cpu_rst low, o_done high; consumed SYNC -> LEN (reload), other bytes ignored.
REQ-023 ERR: o_cpu_rst high, o_err high; consumed SYNC -> LEN, clearing o_err.
REQ-024 o_cpu_rst high in every state except RUN; it deasserts the cycle after CHK accepts a good checksum.
REQ-025 o_ready high in all states except WRITE; bytes presented while o_ready low are not consumed and must be held by the source.
REQ-026 A SYNC value inside LEN/HI/LO/CHK is data, not a restart.
REQ-027 o_instr holds its last value outside WRITE; o_we low outside WRITE.

Reset
REQ-028 i_rst high at a clock edge forces IDLE, o_we=0, o_cpu_rst=1, o_done=0, o_err=0, o_addr=0, o_instr=0, checksum=0, regardless of state, including mid-frame.
REQ-029 o_ready is 1 in the first cycle after reset release.

Structure
REQ-030 State encoding and SYNC default reside in the shared CPU definitions include file alongside the opcode constants.
REQ-031 Single flat module; no sub-modules; CPU instruction memory remains inside CPU.

Verification
REQ-032 Reset, then frame A5 02 12 34 56 78 CHK=02^12^34^56^78=0A -> writes 0x1234@0, 0x5678@1, then o_cpu_rst=0, o_done=1.
REQ-033 Same frame with CHK=0B -> both writes occur, then o_err=1, o_cpu_rst stays 1, o_done=0.
REQ-034 Bytes 00 FF A5 01 A5 A5 CHK -> leading 00/FF ignored; 0xA5A5 written @0; A5 as data not restart.
REQ-035 i_valid held high continuously -> o_ready drops each WRITE cycle, no byte lost or duplicated; check each write by address.
REQ-036 i_rst asserted after HI byte of word 1 -> all outputs at reset values next cycle; fresh frame then loads correctly.
REQ-037 While in RUN send new valid frame -> o_cpu_rst reasserts on LEN entry, new program written, CPU released after good CHK.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared CPU definitions: loader state encoding, frame header default and datapath widths.
package prog_loader_pkg;

   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned INSTR_W = 16;

   localparam logic [BYTE_W-1:0] SYNC_DEFAULT = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN   = 3'd1,
      ST_HI    = 3'd2,
      ST_LO    = 3'd3,
      ST_WRITE = 3'd4,
      ST_CHK   = 3'd5,
      ST_RUN   = 3'd6,
      ST_ERR   = 3'd7
   } state_t;

endpackage

// File: rtl/prog_loader.sv
// Serial-link program loader: parses SYNC/LEN/data/CHK frames, writes CPU instruction
// memory one word at a time and holds the CPU in reset until a frame checks out.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int unsigned       ADDR_W = 8,
   parameter logic [BYTE_W-1:0] SYNC   = SYNC_DEFAULT
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [BYTE_W-1:0]  i_byte,
   input  logic               i_valid,
   output logic               o_ready,
   output logic [INSTR_W-1:0] o_instr,
   output logic [ADDR_W-1:0]  o_addr,
   output logic               o_we,
   output logic               o_cpu_rst,
   output logic               o_done,
   output logic               o_err
);

   state_t            state, state_d;
   logic [BYTE_W-1:0] len_q, chk_q;
   logic              take;
   logic              last_word;
   logic              ready_d, we_d, cpu_rst_d, done_d, err_d;

   assign take = i_valid && o_ready;

   // LEN of 0 means a full 2^ADDR_W-word program: the incremented address wraps to 0 then.
   assign last_word = (o_addr + ADDR_W'(1)) == ADDR_W'(len_q);

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= ST_IDLE;
      else       state <= state_d;
   end

   // Next-state logic; a SYNC byte only restarts a frame from IDLE, RUN or ERR
   always_comb begin
      state_d = state;
      case (state)
         ST_IDLE:  if (take && i_byte == SYNC) state_d = ST_LEN;
         ST_LEN:   if (take) state_d = ST_HI;
         ST_HI:    if (take) state_d = ST_LO;
         ST_LO:    if (take) state_d = ST_WRITE;
         ST_WRITE: state_d = last_word ? ST_CHK : ST_HI;
         ST_CHK:   if (take) state_d = (i_byte == chk_q) ? ST_RUN : ST_ERR;
         ST_RUN:   if (take && i_byte == SYNC) state_d = ST_LEN;
         ST_ERR:   if (take && i_byte == SYNC) state_d = ST_LEN;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Control outputs decoded from the upcoming state, registered below
   always_comb begin
      ready_d   = 1'b1;
      we_d      = 1'b0;
      cpu_rst_d = 1'b1;
      done_d    = 1'b0;
      err_d     = 1'b0;
      case (state_d)
         ST_WRITE: begin
            ready_d = 1'b0;
            we_d    = 1'b1;
         end
         ST_RUN: begin
            cpu_rst_d = 1'b0;
            done_d    = 1'b1;
         end
         ST_ERR:  err_d = 1'b1;
         default: ;
      endcase
   end

   // Registered outputs and frame datapath (word count, running XOR, address, instruction)
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_ready   <= 1'b1;
         o_we      <= 1'b0;
         o_cpu_rst <= 1'b1;
         o_done    <= 1'b0;
         o_err     <= 1'b0;
         o_addr    <= '0;
         o_instr   <= '0;
         len_q     <= '0;
         chk_q     <= '0;
      end else begin
         o_ready   <= ready_d;
         o_we      <= we_d;
         o_cpu_rst <= cpu_rst_d;
         o_done    <= done_d;
         o_err     <= err_d;
         case (state)
            ST_LEN: if (take) begin
               len_q  <= i_byte;
               chk_q  <= i_byte;
               o_addr <= '0;
            end
            ST_HI: if (take) begin
               o_instr[15:8] <= i_byte;
               chk_q         <= chk_q ^ i_byte;
            end
            ST_LO: if (take) begin
               o_instr[7:0] <= i_byte;
               chk_q        <= chk_q ^ i_byte;
            end
            ST_WRITE: o_addr <= o_addr + ADDR_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames with hand-computed checksums, write capture by address.
module tb_prog_loader;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [7:0]  i_byte;
   logic        i_valid;
   logic        o_ready;
   logic [15:0] o_instr;
   logic [7:0]  o_addr;
   logic        o_we;
   logic        o_cpu_rst;
   logic        o_done;
   logic        o_err;

   prog_loader #(.ADDR_W(8), .SYNC(8'hA5)) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_byte    (i_byte),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .o_instr   (o_instr),
      .o_addr    (o_addr),
      .o_we      (o_we),
      .o_cpu_rst (o_cpu_rst),
      .o_done    (o_done),
      .o_err     (o_err)
   );

   always #5 i_clk = ~i_clk;

   int tests  = 0;
   int failed = 0;
   int ready_viol = 0;
   int we_viol    = 0;
   logic we_prev  = 1'b0;

   logic [7:0]  seq[$];
   logic [31:0] wr_addr[$], wr_data[$], exp_addr[$], exp_data[$];

   // Capture every write strobe; flag strobes longer than one cycle or with o_ready high
   always @(negedge i_clk) begin
      if (o_we) begin
         wr_addr.push_back(32'(o_addr));
         wr_data.push_back(32'(o_instr));
         if (o_ready) ready_viol++;
         if (we_prev) we_viol++;
      end
      we_prev = o_we;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present each byte of seq until consumed; gap=1 drops i_valid between bytes
   task automatic send_seq(input bit gap);
      foreach (seq[k]) begin
         int n;
         @(negedge i_clk);
         i_byte  = seq[k];
         i_valid = 1'b1;
         n = 0;
         while (!o_ready && n < 8) begin
            @(negedge i_clk);
            n++;
         end
         if (!o_ready) check("ready_timeout", 32'(o_ready), 32'd1);
         @(posedge i_clk);
         #1;
         if (gap) i_valid = 1'b0;
      end
   endtask

   task automatic idle();
      @(negedge i_clk);
      i_valid = 1'b0;
   endtask

   task automatic compare_writes(input string tag);
      int n;
      check($sformatf("%s_count", tag), 32'(wr_addr.size()), 32'(exp_addr.size()));
      n = (wr_addr.size() < exp_addr.size()) ? wr_addr.size() : exp_addr.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_addr%0d", tag, i), wr_addr[i], exp_addr[i]);
         check($sformatf("%s_data%0d", tag, i), wr_data[i], exp_data[i]);
      end
      wr_addr.delete(); wr_data.delete(); exp_addr.delete(); exp_data.delete();
   endtask

   task automatic check_status(input string tag, input logic cpu_rst, input logic done,
                               input logic err);
      check({tag, "_cpu_rst"}, 32'(o_cpu_rst), 32'(cpu_rst));
      check({tag, "_done"},    32'(o_done),    32'(done));
      check({tag, "_err"},     32'(o_err),     32'(err));
   endtask

   initial begin
      logic [7:0] chk;
      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_byte  = 8'h00;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
      check("rst_ready", 32'(o_ready), 32'd1);
      check("rst_we",    32'(o_we),    32'd0);
      check("rst_addr",  32'(o_addr),  32'd0);
      check("rst_instr", 32'(o_instr), 32'd0);
      check_status("rst", 1'b1, 1'b0, 1'b0);

      // Basic two-word frame with good checksum
      seq = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0A};
      exp_addr = '{32'd0, 32'd1};
      exp_data = '{32'h1234, 32'h5678};
      send_seq(1'b1);
      idle();
      compare_writes("frameA");
      check_status("frameA", 1'b0, 1'b1, 1'b0);
      check("frameA_instr_hold", 32'(o_instr), 32'h5678);

      // Reload while running: CPU goes back into reset as soon as SYNC is taken
      seq = '{8'hA5};
      send_seq(1'b1);
      check_status("reload_len", 1'b1, 1'b0, 1'b0);
      seq = '{8'h01, 8'hBE, 8'hEF, 8'h50};
      exp_addr = '{32'd0};
      exp_data = '{32'hBEEF};
      send_seq(1'b1);
      idle();
      compare_writes("reload");
      check_status("reload", 1'b0, 1'b1, 1'b0);

      // Bad checksum: writes still happen, loader parks in error
      seq = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0B};
      exp_addr = '{32'd0, 32'd1};
      exp_data = '{32'h1234, 32'h5678};
      send_seq(1'b1);
      idle();
      compare_writes("badchk");
      check_status("badchk", 1'b1, 1'b0, 1'b1);

      // Non-SYNC bytes ignored in error; SYNC clears error; SYNC value inside frame is data
      seq = '{8'h00, 8'hFF};
      send_seq(1'b1);
      check_status("err_ignore", 1'b1, 1'b0, 1'b1);
      seq = '{8'hA5};
      send_seq(1'b1);
      check_status("err_clear", 1'b1, 1'b0, 1'b0);
      seq = '{8'h01, 8'hA5, 8'hA5, 8'h01};
      exp_addr = '{32'd0};
      exp_data = '{32'hA5A5};
      send_seq(1'b1);
      idle();
      compare_writes("syncdata");
      check_status("syncdata", 1'b0, 1'b1, 1'b0);

      // Reset mid-frame after the high byte of word 1
      seq = '{8'hA5, 8'h02, 8'h11};
      send_seq(1'b1);
      check("midrst_pre_instr", 32'(o_instr), 32'h11A5);
      @(negedge i_clk);
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      check("midrst_ready", 32'(o_ready), 32'd1);
      check("midrst_we",    32'(o_we),    32'd0);
      check("midrst_addr",  32'(o_addr),  32'd0);
      check("midrst_instr", 32'(o_instr), 32'd0);
      check_status("midrst", 1'b1, 1'b0, 1'b0);
      @(negedge i_clk);
      i_rst = 1'b0;
      seq = '{8'hA5, 8'h01, 8'hCA, 8'hFE, 8'h35};
      exp_addr = '{32'd0};
      exp_data = '{32'hCAFE};
      send_seq(1'b1);
      idle();
      compare_writes("postrst");
      check_status("postrst", 1'b0, 1'b1, 1'b0);

      // i_valid held high throughout: WRITE stalls must not drop or repeat bytes
      seq = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h04};
      exp_addr = '{32'd0, 32'd1, 32'd2};
      exp_data = '{32'h0102, 32'h0304, 32'h0506};
      send_seq(1'b0);
      idle();
      compare_writes("stream");
      check_status("stream", 1'b0, 1'b1, 1'b0);

      // LEN = 0: full 256-word program, address wraps exactly once at the end
      seq = '{8'hA5, 8'h00};
      chk = 8'h00;
      for (int i = 0; i < 256; i++) begin
         seq.push_back(8'(i));
         seq.push_back(~8'(i));
         chk = chk ^ 8'(i) ^ ~8'(i);
         exp_addr.push_back(32'(i));
         exp_data.push_back({16'h0, 8'(i), ~8'(i)});
      end
      seq.push_back(chk);
      send_seq(1'b0);
      idle();
      compare_writes("full");
      check("full_addr_wrap", 32'(o_addr), 32'd0);
      check_status("full", 1'b0, 1'b1, 1'b0);

      repeat (3) @(negedge i_clk);
      check("full_no_extra_we", 32'(wr_addr.size()), 32'd0);
      check("we_one_cycle",   32'(we_viol),    32'd0);
      check("ready_low_in_we", 32'(ready_viol), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
